maxpool_relu: RTL and testbench



---
 rtl/maxpool_relu.sv | 99 +++++++++
 tb/tb_maxpool_relu.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_relu.sv
// 2x2 stride-2 max pooling of a 3-channel signed raster stream, using one half-row buffer per channel.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero; otherwise the signed max passes through.
module maxpool_relu #(
  parameter int WIDTH     = 24,
  parameter int HEIGHT    = 24,
  parameter int DATA_BITS = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] conv_in_1,
  input  logic [DATA_BITS-1:0] conv_in_2,
  input  logic [DATA_BITS-1:0] conv_in_3,
  output logic [DATA_BITS-1:0] pool_out_1,
  output logic [DATA_BITS-1:0] pool_out_2,
  output logic [DATA_BITS-1:0] pool_out_3,
  output logic                 valid_out
);

  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int HALF = WIDTH / 2;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef logic signed [DATA_BITS-1:0] sample_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [BW-1:0] bidx;
  logic          last_col;
  logic          last_row;

  sample_t sample [3];
  sample_t hold   [3];
  sample_t pool   [3];
  sample_t hmax   [3];
  sample_t vmax   [3];
  sample_t res    [3];
  sample_t line_buf [3][HALF];

  always_comb begin
    sample[0] = conv_in_1;
    sample[1] = conv_in_2;
    sample[2] = conv_in_3;
    bidx      = BW'(col >> 1);
    last_col  = (col == CW'(WIDTH - 1));
    last_row  = (row == RW'(HEIGHT - 1));
    for (int unsigned ch = 0; ch < 3; ch++) begin
      hmax[ch] = (hold[ch] > sample[ch]) ? hold[ch] : sample[ch];
      vmax[ch] = (line_buf[ch][bidx] > hmax[ch]) ? line_buf[ch][bidx] : hmax[ch];
`ifdef MAXPOOL_RELU_EN
      res[ch]  = vmax[ch][DATA_BITS-1] ? '0 : vmax[ch];
`else
      res[ch]  = vmax[ch];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      valid_out <= 1'b0;
      for (int unsigned ch = 0; ch < 3; ch++) begin
        hold[ch] <= '0;
        pool[ch] <= '0;
      end
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        for (int unsigned ch = 0; ch < 3; ch++) begin
          if (!col[0]) hold[ch] <= sample[ch];
        end
        if (col[0] && row[0]) begin
          for (int unsigned ch = 0; ch < 3; ch++) pool[ch] <= res[ch];
          valid_out <= 1'b1;
        end
      end
    end
  end

  // Buffer holds even-row horizontal maxima; never reset since every entry is written before use.
  always_ff @(posedge clk) begin
    if (valid_in && !rst && col[0] && !row[0]) begin
      for (int unsigned ch = 0; ch < 3; ch++) line_buf[ch][bidx] <= hmax[ch];
    end
  end

  assign pool_out_1 = pool[0];
  assign pool_out_2 = pool[1];
  assign pool_out_3 = pool[2];

endmodule

// File: tb/tb_maxpool_relu.sv
// Self-checking bench for maxpool_relu: scoreboard driven by a 2x2 block reference over a stored image.
module tb_maxpool_relu;
  localparam int W  = 24;
  localparam int H  = 24;
  localparam int DB = 12;

  typedef logic [DB-1:0] d_t;
  typedef struct packed { d_t p1; d_t p2; d_t p3; } out_t;
  typedef struct { int a; int b; int c; int d; d_t exp_relu; d_t exp_raw; string name; } vec_t;

  logic clk, rst, valid_in, valid_out;
  d_t   conv_in_1, conv_in_2, conv_in_3;
  d_t   pool_out_1, pool_out_2, pool_out_3;

  maxpool_relu #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .conv_in_1(conv_in_1), .conv_in_2(conv_in_2), .conv_in_3(conv_in_3),
    .pool_out_1(pool_out_1), .pool_out_2(pool_out_2), .pool_out_3(pool_out_3),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   img [3][H][W];
  out_t exp_q [$];
  out_t log_q [$];
  out_t ref_q [$];
  int   checks  = 0;
  int   errors  = 0;
  int   strobes = 0;
  logic prev_v  = 1'b0;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic d_t act_fn(input int v);
`ifdef MAXPOOL_RELU_EN
    if (v < 0) return '0;
`endif
    return d_t'(v);
  endfunction

  function automatic out_t blk_exp(input int r, input int c);
    int m [3];
    for (int ch = 0; ch < 3; ch++) begin
      m[ch] = img[ch][r-1][c-1];
      if (img[ch][r-1][c] > m[ch]) m[ch] = img[ch][r-1][c];
      if (img[ch][r][c-1] > m[ch]) m[ch] = img[ch][r][c-1];
      if (img[ch][r][c]   > m[ch]) m[ch] = img[ch][r][c];
    end
    return '{p1: act_fn(m[0]), p2: act_fn(m[1]), p3: act_fn(m[2])};
  endfunction

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      out_t got, e;
      got = '{p1: pool_out_1, p2: pool_out_2, p3: pool_out_3};
      chk("no_back_to_back", {35'd0, prev_v}, 36'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 36'(got), 36'h0_0000_0000 ^ 36'(got) ^ 36'hF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard", 36'(got), 36'(e));
      end
      log_q.push_back(got);
      strobes++;
    end
    prev_v = (valid_out === 1'b1);
  end

  task automatic drive_pixel(input int r, input int c);
    valid_in  = 1'b1;
    conv_in_1 = d_t'(img[0][r][c]);
    conv_in_2 = d_t'(img[1][r][c]);
    conv_in_3 = d_t'(img[2][r][c]);
    if ((r % 2 == 1) && (c % 2 == 1)) exp_q.push_back(blk_exp(r, c));
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drive_frame(input int n, input int duty);
    for (int i = 0; i < n; i++) begin
      if (duty < 100) begin
        while (int'($urandom_range(0, 99)) >= duty) begin
          valid_in = 1'b0;
          @(posedge clk); #1;
        end
      end
      drive_pixel((i / W) % H, i % W);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    chk(name, 36'(exp_q.size()), 36'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    log_q.delete();
    strobes = 0;
  endtask

  task automatic set_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[0][r][c] = r * W + c;
        img[1][r][c] = -(r * W + c);
        img[2][r][c] = -(r * W + c);
      end
  endtask

  task automatic cmp_logs(input string name, input int off);
    int bad = 0;
    for (int i = 0; i < ref_q.size(); i++)
      if (off + i >= log_q.size() || log_q[off + i] !== ref_q[i]) bad++;
    chk(name, 36'(bad), 36'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    d_t e2_first, e2_second;
    vecs[0] = '{-5, -7, -3, -9, 12'h000, 12'hFFD, "neg_block"};
    vecs[1] = '{-2048, 2047, -2048, -2048, 12'h7FF, 12'h7FF, "extremes"};
    vecs[2] = '{-1, -1, -1, -1, 12'h000, 12'hFFF, "all_minus_one"};
    vecs[3] = '{5, -2048, 3, 100, 12'h064, 12'h064, "max_bottom_right"};
    vecs[4] = '{-2048, -2048, -2048, -2048, 12'h000, 12'h800, "all_min"};
    vecs[5] = '{2047, 0, 0, -2048, 12'h7FF, 12'h7FF, "max_top_left"};
    vecs[6] = '{7, 7, 7, 7, 12'h007, 12'h007, "ties"};
`ifdef MAXPOOL_RELU_EN
    e2_first = 12'h000; e2_second = 12'h000;
`else
    e2_first = 12'h000; e2_second = 12'hFFE;
`endif

    rst = 1'b1; valid_in = 1'b0;
    conv_in_1 = '0; conv_in_2 = '0; conv_in_3 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_out", {35'd0, valid_out}, 36'd0);
    chk("reset_pool_out", {pool_out_1, pool_out_2, pool_out_3}, 36'd0);
    rst = 1'b0;

    // Continuous ramp frame; becomes the reference log.
    set_ramp();
    drive_frame(W * H, 100);
    drain("ramp_drain");
    chk("ramp_strobes", 36'(strobes), 36'd144);
    if (log_q.size() >= 144) begin
      chk("ramp_first_ch1", 36'(log_q[0].p1), 36'd25);
      chk("ramp_second_ch1", 36'(log_q[1].p1), 36'd27);
      chk("ramp_last_ch1", 36'(log_q[143].p1), 36'd575);
      chk("ramp_first_ch2", 36'(log_q[0].p2), 36'(e2_first));
      chk("ramp_second_ch3", 36'(log_q[1].p3), 36'(e2_second));
    end
    ref_q = log_q;

    // Random ~40% valid duty.
    do_reset();
    drive_frame(W * H, 40);
    drain("duty_drain");
    chk("duty_strobes", 36'(strobes), 36'd144);
    cmp_logs("duty_vs_continuous", 0);

    // Reset after 300 accepted samples, with a sample offered during reset.
    do_reset();
    drive_frame(300, 100);
    drain("partial_drain");
    rst = 1'b1; valid_in = 1'b1;
    conv_in_1 = 12'h123; conv_in_2 = 12'h456; conv_in_3 = 12'h789;
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    exp_q.delete(); log_q.delete(); strobes = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_quiet", 36'(strobes), 36'd0);
    drive_frame(W * H, 100);
    drain("midreset_drain");
    chk("midreset_strobes", 36'(strobes), 36'd144);
    cmp_logs("midreset_vs_continuous", 0);

    // Reset coinciding with the odd/odd sample: strobe must not appear.
    do_reset();
    drive_frame(W + 1, 100);
    rst = 1'b1; valid_in = 1'b1;
    conv_in_1 = d_t'(img[0][1][1]); conv_in_2 = d_t'(img[1][1][1]); conv_in_3 = d_t'(img[2][1][1]);
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wins_no_strobe", 36'(strobes), 36'd0);
    exp_q.delete(); log_q.delete(); strobes = 0;
    drive_frame(2 * W, 100);
    drain("after_cancel_drain");
    chk("after_cancel_strobes", 36'(strobes), 36'd12);

    // Table-driven single-block vectors at block (0,0).
    for (int v = 0; v < 7; v++) begin
      d_t e;
`ifdef MAXPOOL_RELU_EN
      e = vecs[v].exp_relu;
`else
      e = vecs[v].exp_raw;
`endif
      do_reset();
      for (int ch = 0; ch < 3; ch++)
        for (int r = 0; r < H; r++)
          for (int c = 0; c < W; c++) img[ch][r][c] = 0;
      for (int ch = 0; ch < 3; ch++) begin
        img[ch][0][0] = vecs[v].a;
        img[ch][0][1] = vecs[v].b;
        img[ch][1][0] = vecs[v].c;
        img[ch][1][1] = vecs[v].d;
      end
      drive_frame(2 * W, 100);
      drain({vecs[v].name, "_drain"});
      chk({vecs[v].name, "_strobes"}, 36'(strobes), 36'd12);
      if (log_q.size() > 0) chk(vecs[v].name, 36'(log_q[0]), {e, e, e});
    end

    // Two back-to-back frames, no idle cycles.
    do_reset();
    set_ramp();
    drive_frame(2 * W * H, 100);
    drain("b2b_drain");
    chk("b2b_strobes", 36'(strobes), 36'd288);
    cmp_logs("b2b_frame1", 0);
    cmp_logs("b2b_frame2", 144);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
